// File: rtl/fb_hazard_unit.sv
// Decode-stage forwarding select and load-use interlock for the five-stage pipeline.
// Build option FB_FORWARD_EN: defined = forwarding; undefined = full interlock, selects tied to 00.
module fb_hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        ex_flush,
    output logic        stall_if_id,
    output logic        bubble_ex,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [31:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } exr_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } memr_t;

    exr_t        exr_q, exr_d;
    memr_t       memr_q, memr_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic ex_match_a, ex_match_b, mem_match_a, mem_match_b;
    logic ex_match, mem_match, load_use, hazard, insert_bubble;

    function automatic logic rec_match(input logic v, input logic rw, input logic [4:0] rd,
                                       input logic id_v, input logic use_bit, input logic [4:0] rs);
        return v && rw && (rd != 5'd0) && id_v && use_bit && (rs == rd);
    endfunction

    always_comb begin
        ex_match_a  = rec_match(exr_q.valid, exr_q.regwrite, exr_q.rd, id_valid, id_use_rs1, id_rs1);
        ex_match_b  = rec_match(exr_q.valid, exr_q.regwrite, exr_q.rd, id_valid, id_use_rs2, id_rs2);
        mem_match_a = rec_match(memr_q.valid, memr_q.regwrite, memr_q.rd, id_valid, id_use_rs1, id_rs1);
        mem_match_b = rec_match(memr_q.valid, memr_q.regwrite, memr_q.rd, id_valid, id_use_rs2, id_rs2);
        ex_match    = ex_match_a | ex_match_b;
        mem_match   = mem_match_a | mem_match_b;
        load_use    = ex_match & exr_q.memread;
`ifdef FB_FORWARD_EN
        hazard      = load_use;
`else
        // Without forwarding any in-flight producer must drain to WB first.
        hazard      = ex_match | mem_match | load_use;
`endif
    end

    assign stall_if_id   = hazard & ~ex_flush;
    assign bubble_ex     = stall_if_id;
    assign insert_bubble = hazard | ex_flush;
    assign stall_cnt     = stall_cnt_q;

    always_comb begin
        exr_d       = insert_bubble ? '0 : {id_valid, id_rd, id_regwrite, id_memread};
        memr_d      = {exr_q.valid, exr_q.rd, exr_q.regwrite};
        stall_cnt_d = stall_cnt_q;
        if (stall_if_id && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exr_q       <= '0;
            memr_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            exr_q       <= exr_d;
            memr_q      <= memr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef FB_FORWARD_EN
    logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0] fwd_b_sel_q, fwd_b_sel_d;

    // Newest producer wins, so the EX record is tested before the MEM record.
    always_comb begin
        fwd_a_sel_d = 2'b00;
        fwd_b_sel_d = 2'b00;
        if (!insert_bubble) begin
            if (ex_match_a)       fwd_a_sel_d = 2'b10;
            else if (mem_match_a) fwd_a_sel_d = 2'b01;
            if (ex_match_b)       fwd_b_sel_d = 2'b10;
            else if (mem_match_b) fwd_b_sel_d = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_sel_q <= 2'b00;
            fwd_b_sel_q <= 2'b00;
        end else begin
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
        end
    end

    assign fwd_a_sel = fwd_a_sel_q;
    assign fwd_b_sel = fwd_b_sel_q;
`else
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

endmodule

// File: tb/tb_fb_hazard_unit.sv
// Directed bench for fb_hazard_unit; expectations follow FB_FORWARD_EN like the design.
module tb_fb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_regwrite, id_memread, ex_flush;
    logic        stall_if_id, bubble_ex;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    fb_hazard_unit dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .ex_flush    (ex_flush),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one ID-stage instruction for the next clock edge; outputs settle 1 ns later.
    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr; ex_flush = fl;
        #1;
        $display("step t=%0t v=%0b rs1=%0d rs2=%0d rd=%0d mr=%0b fl=%0b rst=%0b -> stall=%0b bub=%0b fa=%b fb=%b cnt=%0d",
                 $time, v, rs1, rs2, rd, mr, fl, rst, stall_if_id, bubble_ex, fwd_a_sel, fwd_b_sel, stall_cnt);
    endtask

    task automatic nop();                                         issue(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alu(input logic [4:0] rd, rs1, rs2);           issue(1, rs1, rs2, 1, 1, rd, 1, 0, 0); endtask
    task automatic addi(input logic [4:0] rd, rs1);               issue(1, rs1, 0, 1, 0, rd, 1, 0, 0); endtask
    task automatic lw(input logic [4:0] rd, rs1);                 issue(1, rs1, 0, 1, 0, rd, 1, 1, 0); endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; ex_flush = 0;
        exp_cnt = 0;

        // Reset state
        nop(); nop();
        chk("rst_stall", {31'd0, stall_if_id}, 0);
        chk("rst_bubble", {31'd0, bubble_ex}, 0);
        chk("rst_fwd_a", {30'd0, fwd_a_sel}, 0);
        chk("rst_fwd_b", {30'd0, fwd_b_sel}, 0);
        chk("rst_cnt", stall_cnt, 0);
        rst = 1'b0;
        nop(); nop();

        // add x5,x1,x2 ; sub x6,x5,x3
        alu(5, 1, 2);
        chk("b2b_prod_stall", {31'd0, stall_if_id}, 0);
        alu(6, 5, 3);
`ifdef FB_FORWARD_EN
        chk("b2b_stall", {31'd0, stall_if_id}, 0);
        nop();
        chk("b2b_fwd_a", {30'd0, fwd_a_sel}, 32'd2);
        chk("b2b_fwd_b", {30'd0, fwd_b_sel}, 0);
`else
        chk("il_b2b_stall1", {31'd0, stall_if_id}, 1);
        chk("il_b2b_bubble1", {31'd0, bubble_ex}, 1);
        alu(6, 5, 3);
        chk("il_b2b_stall2", {31'd0, stall_if_id}, 1);
        alu(6, 5, 3);
        chk("il_b2b_stall3", {31'd0, stall_if_id}, 0);
        exp_cnt = 2;
        nop();
        chk("il_b2b_fwd_a", {30'd0, fwd_a_sel}, 0);
        chk("il_b2b_fwd_b", {30'd0, fwd_b_sel}, 0);
`endif
        chk("b2b_cnt", stall_cnt, exp_cnt);
        nop(); nop();

        // addi x7,x0,1 ; addi x7,x0,2 ; add x8,x7,x7
        addi(7, 0); addi(7, 0);
        alu(8, 7, 7);
`ifdef FB_FORWARD_EN
        chk("prio_stall", {31'd0, stall_if_id}, 0);
        nop();
        chk("prio_fwd_a", {30'd0, fwd_a_sel}, 32'd2);
        chk("prio_fwd_b", {30'd0, fwd_b_sel}, 32'd2);
`else
        chk("il_prio_stall1", {31'd0, stall_if_id}, 1);
        alu(8, 7, 7);
        chk("il_prio_stall2", {31'd0, stall_if_id}, 1);
        alu(8, 7, 7);
        chk("il_prio_stall3", {31'd0, stall_if_id}, 0);
        exp_cnt = exp_cnt + 2;
        nop();
`endif
        chk("prio_cnt", stall_cnt, exp_cnt);
        nop(); nop();

        // addi x7 ; addi x10 ; add x8,x7,x7
        addi(7, 0); addi(10, 0);
        alu(8, 7, 7);
`ifdef FB_FORWARD_EN
        chk("dist2_stall", {31'd0, stall_if_id}, 0);
        nop();
        chk("dist2_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
        chk("dist2_fwd_b", {30'd0, fwd_b_sel}, 32'd1);
`else
        chk("il_dist2_stall1", {31'd0, stall_if_id}, 1);
        alu(8, 7, 7);
        chk("il_dist2_stall2", {31'd0, stall_if_id}, 0);
        exp_cnt = exp_cnt + 1;
        nop();
`endif
        chk("dist2_cnt", stall_cnt, exp_cnt);
        nop(); nop();

        // lw x4,0(x1) ; add x9,x4,x4
        lw(4, 1);
        alu(9, 4, 4);
        chk("lu_stall", {31'd0, stall_if_id}, 1);
        chk("lu_bubble", {31'd0, bubble_ex}, 1);
        chk("lu_cnt_before", stall_cnt, exp_cnt);
        alu(9, 4, 4);
        exp_cnt = exp_cnt + 1;
        chk("lu_cnt_after1", stall_cnt, exp_cnt);
`ifdef FB_FORWARD_EN
        chk("lu_stall_end", {31'd0, stall_if_id}, 0);
        nop();
        chk("lu_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
        chk("lu_fwd_b", {30'd0, fwd_b_sel}, 32'd1);
`else
        chk("il_lu_stall2", {31'd0, stall_if_id}, 1);
        alu(9, 4, 4);
        chk("il_lu_stall_end", {31'd0, stall_if_id}, 0);
        exp_cnt = exp_cnt + 1;
        nop();
        chk("il_lu_fwd_a", {30'd0, fwd_a_sel}, 0);
`endif
        chk("lu_cnt", stall_cnt, exp_cnt);
        nop(); nop();

        // lw x0 ; add x9,x0,x0
        lw(0, 1);
        alu(9, 0, 0);
        chk("x0_stall", {31'd0, stall_if_id}, 0);
        nop();
        chk("x0_fwd_a", {30'd0, fwd_a_sel}, 0);
        chk("x0_fwd_b", {30'd0, fwd_b_sel}, 0);

        // lw x3 ; lui x3
        lw(3, 1);
        issue(1, 3, 3, 0, 0, 3, 1, 0, 0);
        chk("lui_stall", {31'd0, stall_if_id}, 0);
        nop(); nop();

        // lw x12 ; invalid slot reading x12
        lw(12, 1);
        issue(0, 12, 12, 1, 1, 0, 0, 0, 0);
        chk("invalid_stall", {31'd0, stall_if_id}, 0);
        chk("cnt_unchanged", stall_cnt, exp_cnt);
        nop(); nop();

        // lw x4 ; add x9,x4,x4 with a flush in the hazard cycle
        lw(4, 1);
        issue(1, 4, 4, 1, 1, 9, 1, 0, 1);
        chk("flush_stall", {31'd0, stall_if_id}, 0);
        chk("flush_bubble", {31'd0, bubble_ex}, 0);
        alu(9, 4, 4);
        chk("flush_cnt", stall_cnt, exp_cnt);
        chk("flush_fwd_a", {30'd0, fwd_a_sel}, 0);
`ifdef FB_FORWARD_EN
        chk("flush_after_stall", {31'd0, stall_if_id}, 0);
        nop();
        chk("flush_after_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
`else
        chk("il_flush_after_stall", {31'd0, stall_if_id}, 1);
        alu(9, 4, 4);
        chk("il_flush_after_stall2", {31'd0, stall_if_id}, 0);
        exp_cnt = exp_cnt + 1;
        nop();
`endif
        chk("flush_cnt_end", stall_cnt, exp_cnt);
        nop(); nop();

        // Counter saturation
        nop();
        force dut.stall_cnt_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.stall_cnt_d;
        nop();
        chk("sat_loaded", stall_cnt, 32'hFFFF_FFFF);
        lw(4, 1);
        alu(9, 4, 4);
        chk("sat_stall", {31'd0, stall_if_id}, 1);
        alu(9, 4, 4);
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        nop(); nop(); nop();

        // Reset in the middle of a load-use stall
        lw(4, 1);
        alu(9, 4, 4);
        chk("rstmid_stall", {31'd0, stall_if_id}, 1);
        rst = 1'b1;
        alu(9, 4, 4);
        rst = 1'b0;
        chk("rstmid_stall_after", {31'd0, stall_if_id}, 0);
        chk("rstmid_bubble_after", {31'd0, bubble_ex}, 0);
        chk("rstmid_fwd_a", {30'd0, fwd_a_sel}, 0);
        chk("rstmid_fwd_b", {30'd0, fwd_b_sel}, 0);
        chk("rstmid_cnt", stall_cnt, 0);
        nop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_hazard_unit.md
# fb_hazard_unit

Forwarding and hazard control for the five-stage pipeline. It sits in the decode stage and tracks the destination registers of the two older in-flight instructions (EX and MEM) in its own shadow pipeline. It registers the 2-bit operand-select codes consumed by the EX-stage forwarding muxes, and it raises stall/bubble controls for load-use hazards. The register file is write-first, so a WB-stage write is visible to a same-cycle ID read and needs no handling here.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  source register 1 of ID instruction
- id_rs2  in  5  source register 2 of ID instruction
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_rd  in  5  destination register of ID instruction
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- ex_flush  in  1  taken branch/jump resolved in EX; squash ID
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX register
- fwd_a_sel  out  2  operand A select for the instruction now in EX
- fwd_b_sel  out  2  operand B select for the instruction now in EX
- stall_cnt  out  32  count of stall cycles, saturating

## Operation
- Select codes:
  - 00: register-file data.
  - 10: EX/MEM ALU result (producer one instruction ahead).
  - 01: MEM/WB data (producer two instructions ahead).
- Shadow records:
  - exr = {valid, rd, regwrite, memread}
  - memr = {valid, rd, regwrite}
- Every cycle, memr takes exr. exr takes the ID fields, or all-zero when bubble_ex or ex_flush is asserted.
- A match against a record requires all of: record valid, record regwrite, rd != 0, id_valid, the matching use bit set, and rs == rd.
- Forward decision per operand is made in ID:
  - A match on exr gives 10.
  - Otherwise a match on memr gives 01.
  - Otherwise 00.
  - exr has priority over memr when both match the same register.
- Load-use hazard: a match on exr while exr.memread = 1.
- Outputs are combinational: stall_if_id = bubble_ex = hazard & ~ex_flush. Flush dominates stall.
- stall_cnt increments by 1 in each cycle that stall_if_id = 1 and holds at 0xFFFF_FFFF.

## Timing
- Reset values:
  - exr, memr, fwd_a_sel, fwd_b_sel: all zero.
  - stall_cnt: 0.
  - stall_if_id, bubble_ex: 0 (records are invalid after reset).
- fwd_*_sel is registered. The code computed in cycle N (instruction in ID) is presented in cycle N+1, when that instruction is in EX. Latency is 1 cycle.
- On a bubble or flush edge, fwd_*_sel loads 00.
- Load-use gives exactly one stall cycle:
  - The stall cycle loads a bubble into exr, and the load moves to memr.
  - In the next cycle the dependent instruction matches memr and gets code 01.
- A flush in a stall cycle:
  - No stall occurs.
  - The bubble is inserted anyway, because of the flush.
  - stall_cnt does not increment.
- Reset asserted mid-stall clears all records. The stall deasserts in the cycle after the reset edge.
- A hazard check with id_valid = 0 never stalls.

## Configuration
- FB_FORWARD_EN defined: forwarding as described above; only load-use hazards stall.
- FB_FORWARD_EN undefined (interlock mode):
  - fwd_a_sel and fwd_b_sel are constant 00.
  - hazard = any match on exr or on memr, regardless of memread.
  - A producer one instruction ahead stalls 2 cycles; one two instructions ahead stalls 1 cycle.
  - stall_cnt counts these cycles.

## Test plan
- Back-to-back forward: `add x5,x1,x2` then `sub x6,x5,x3` -> no stall. fwd_a_sel = 10 in the sub's EX cycle, fwd_b_sel = 00.
- Distance-two forward with priority:
  - `addi x7,x0,1`, `addi x7,x0,2`, `add x8,x7,x7` -> both selects 10 (newest producer wins).
  - With an unrelated instruction in the middle instead -> both selects 01.
- Load-use: `lw x4,0(x1)` then `add x9,x4,x4` -> stall_if_id = bubble_ex = 1 for exactly 1 cycle, stall_cnt 0 -> 1, then fwd_a_sel = fwd_b_sel = 01.
- x0 and unused sources:
  - `lw x0,..` then `add x9,x0,x0` -> no stall, selects 00.
  - `lui x3` after `lw x3` -> no stall (id_use_rs1 = id_use_rs2 = 0).
- Flush versus stall: the load-use pair with ex_flush = 1 in the hazard cycle -> stall_if_id = 0, bubble inserted, stall_cnt unchanged.
- Interlock mode (FB_FORWARD_EN undefined): back-to-back dependent `add` pair -> 2 stall cycles, selects 00, stall_cnt = 2.
- Counter saturation: force 0xFFFF_FFFF, apply a stall -> value unchanged.
- Reset: rst mid-stall -> all outputs 0 on the next cycle.
